fifo_burst_reader: RTL

- Read-side master for the shared fifo primitive. Operates in the rd_clk domain.
- Waits until the fifo holds a full burst, or until a flush is requested. Then issues rd_req strobes and absorbs the fifo's 1-cycle read latency.
- Presents the words on a valid/ready stream with a burst-end marker.
- Sits between the fifo read port and downstream packetising or DMA logic.

---
 rtl/fifo_burst_reader.sv | 117 +++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// Read-side burst master for the shared fifo: gathers a full (or flushed short)
// burst, strobes rd_req, absorbs the 1-cycle read latency and streams words out.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 10,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [ADDR_BITS-1:0]  fifo_usedw,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_req,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDR_BITS-1:0] BL  = ADDR_BITS'(BURST_LEN);
  localparam logic [ADDR_BITS-1:0] ONE = ADDR_BITS'(1);

  state_t                state;
  logic [ADDR_BITS-1:0]  rd_left;
  logic                  flush_pending;
  logic                  inflight;
  logic                  inflight_last;
  logic [1:0]            cnt;
  logic [DATA_WIDTH-1:0] sk_data [2];
  logic [1:0]            sk_last;

  logic       pop;
  logic [1:0] occ;
  logic [1:0] wi;
  logic       start_full;
  logic       start_short;

  assign pop = m_valid & m_ready;
  // Occupancy after this cycle's pop, so a draining buffer still allows one read per cycle.
  assign occ = cnt + {1'b0, inflight} - {1'b0, pop};
  assign wi  = cnt - {1'b0, pop};

  assign start_full  = (state == IDLE) && en && (fifo_usedw >= BL);
  assign start_short = (state == IDLE) && en && !start_full && flush_pending &&
                       !fifo_empty && (fifo_usedw != '0);

  assign fifo_rd_req = (state == READ) && (rd_left != '0) && !fifo_empty && (occ < 2'd2);
  assign m_valid     = (cnt != 2'd0);
  assign m_data      = sk_data[0];
  assign m_last      = sk_last[0] & m_valid;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_left       <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (flush)
        flush_pending <= 1'b1;
      else if (start_short || ((state == IDLE) && flush_pending && fifo_empty))
        flush_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (start_full) begin
            rd_left <= BL;
            state   <= READ;
          end else if (start_short) begin
            rd_left <= fifo_usedw;
            state   <= READ;
          end
        end
        READ: begin
          if (fifo_rd_req) begin
            rd_left <= rd_left - ONE;
            if (rd_left == ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The last-word tag travels with the read so m_last lands on the word that closes the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      cnt           <= 2'd0;
      sk_data[0]    <= '0;
      sk_data[1]    <= '0;
      sk_last       <= 2'b00;
    end else begin
      inflight      <= fifo_rd_req;
      inflight_last <= fifo_rd_req && (rd_left == ONE);
      cnt           <= cnt + {1'b0, inflight} - {1'b0, pop};
      if (pop) begin
        sk_data[0] <= sk_data[1];
        sk_last[0] <= sk_last[1];
      end
      if (inflight) begin
        sk_data[wi[0]] <= fifo_data;
        sk_last[wi[0]] <= inflight_last;
      end
    end
  end

endmodule
